axis_insert_header_pipe: RTL and testbench
==========================================

# axis_insert_header_pipe

Parametrised AXI-Stream header inserter: prepends a per-packet header of 0..DATA_BYTE_WD bytes to every input packet and repacks the payload so output beats stay byte-contiguous. It is a full-throughput, registered-output successor to the single-width header inserter in the stream datapath. New behaviour over that block:
- correct backpressure;
- an extra flush beat when the header plus tail bytes overflow one beat;
- zero-length header pass-through;
- optional packet statistics.

## Interface
- DATA_WD, 32, data width in bits; multiple of 8, minimum 16.
- DATA_BYTE_WD, DATA_WD/8, bytes per beat.
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD), byte-count width.
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- valid_in  in  1  payload beat valid.
- data_in  in  DATA_WD  payload data. Byte 0 is [DATA_WD-1 -: 8] (MSB-first).
- keep_in  in  DATA_BYTE_WD  byte enables. Must be all ones on non-last beats; MSB-aligned and contiguous on the last beat.
- last_in  in  1  last payload beat of the packet.
- ready_in  out  1  payload beat accepted when valid_in && ready_in.
- valid_out, data_out [DATA_WD], keep_out [DATA_BYTE_WD], last_out  out  output stream, all registered.
- ready_out  in  1  downstream ready.
- valid_insert  in  1  header valid.
- data_insert  in  DATA_WD  header; the valid bytes are the lowest byte_insert_cnt bytes.
- keep_insert  in  DATA_BYTE_WD  informational only; ignored by the datapath.
- byte_insert_cnt  in  BYTE_CNT_WD+1  header byte count n. Values above DATA_BYTE_WD are clamped to DATA_BYTE_WD.
- ready_insert  out  1  header accepted when valid_insert && ready_insert.

## Operation
- Notation: W = DATA_BYTE_WD; n = latched header byte count; R = residue register of n bytes.
- FSM states:
  - IDLE: ready_insert=1, ready_in=0. A header handshake latches n and loads R with the low n header bytes, then goes to HDR.
  - HDR and STREAM: ready_insert=0; ready_in = out_free, where out_free = !valid_out || ready_out.
  - FLUSH: ready_in=0, ready_insert=0.
- Payload accept in HDR or STREAM loads the output register:
  - data_out = {R, first W-n bytes of data_in};
  - R ← last n bytes of data_in.
  - HDR → STREAM on a non-last beat.
- Last beat, with m = popcount(keep_in), 1..W:
  - If n+m ≤ W: one output beat with last_out=1 and keep_out = n+m MSB-aligned ones. Go to IDLE.
  - Else: a full beat with keep_out all ones and last_out=0, then go to FLUSH.
  - FLUSH loads data_out = {R, zeros} with keep_out = n+m-W MSB-aligned ones and last_out=1 when out_free, then goes to IDLE.
- Non-last output beats always have keep_out all ones.
- n=0: exact pass-through; flush is never needed.
- n=W: the header is emitted as a whole beat, and the payload is delayed by one beat.
- Single-beat packet: handled by the same rules from HDR.
- Output register: holds data, keep, last and valid stable while valid_out && !ready_out. Loads when out_free and a source exists; otherwise clears valid_out on a handshake.
- Violations: a non-all-ones keep_in on a non-last beat is treated as all ones.

## Timing
- Reset (rst=1 at a clock edge):
  - valid_out=0, data_out=0, keep_out=0, last_out=0;
  - FSM=IDLE, R=0, n=0;
  - ready_in=0, ready_insert=1 combinationally after reset.
- Latency: header handshake at cycle t; first payload handshake at t+1 at the earliest; first output beat valid at t+2.
- Throughput: one beat per cycle within a packet. Per-packet overhead is one header cycle, plus one cycle when FLUSH is needed.
- ready_in and ready_insert are combinational from FSM state, valid_out and ready_out. They have no dependency on valid_in or valid_insert.
- A next-packet header may be accepted in IDLE while the previous last beat is still stalled in the output register.
- rst mid-packet: the packet is dropped, the output register is cleared, and operation resumes in IDLE on the next cycle.

## Configuration
- INS_STATS_EN defined: adds two outputs, both clearing on rst and wrapping modulo 2^16.
  - pkt_cnt [15:0] out: increments on each valid_out && ready_out && last_out.
  - flush_cnt [15:0] out: increments on each FLUSH entry.
- INS_STATS_EN undefined: both ports and their counters are absent; all other behaviour is identical.

## Test plan
All scenarios use DATA_WD=32.
- Overflow flush: n=2, header 0x0000AABB; payload 0x11223344 (keep 1111), then 0x55667788 (keep 1111, last).
  -> Out 0xAABB1122/1111, 0x33445566/1111, 0x77880000/1100 with last=1.
- Single beat, no flush: n=3, header 0x00CCDDEE; payload 0x99000000 (keep 1000, last).
  -> One beat 0xCCDDEE99, keep 1111, last=1.
- Pass-through: n=0; 3-beat packet with last keep 1110.
  -> Output is identical to input, with exactly one bubble before the first beat.
- Backpressure: n=1; ready_out randomly 50% low over 20 packets.
  -> Output stream matches the reference model byte-for-byte; outputs are stable while stalled; no drops or duplicates.
- Clamp and full header: byte_insert_cnt=7.
  -> Behaves as n=4: the first output beat equals data_insert, followed by the payload unshifted.
- Reset mid-packet: assert rst on the second payload beat.
  -> valid_out=0 the next cycle; ready_insert=1; the next packet is correct. With INS_STATS_EN defined, pkt_cnt=0.

Source files
------------

// File: rtl/axis_insert_header_pipe_if.sv
// rtl/axis_insert_header_pipe_if.sv - stream and header handshake interfaces for axis_insert_header_pipe
interface axis_insert_header_pipe_if #(
    parameter int DATA_WD = 32
) ();
    localparam int DATA_BYTE_WD = DATA_WD / 8;

    logic                    tvalid;
    logic [DATA_WD-1:0]      tdata;
    logic [DATA_BYTE_WD-1:0] tkeep;
    logic                    tlast;
    logic                    tready;

    modport master (output tvalid, tdata, tkeep, tlast, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

interface axis_insert_header_pipe_hdr_if #(
    parameter int DATA_WD = 32
) ();
    localparam int DATA_BYTE_WD = DATA_WD / 8;
    localparam int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD);

    logic                    tvalid;
    logic [DATA_WD-1:0]      tdata;
    logic [DATA_BYTE_WD-1:0] tkeep;
    logic [BYTE_CNT_WD:0]    byte_cnt;
    logic                    tready;

    modport master (output tvalid, tdata, tkeep, byte_cnt, input tready);
    modport slave  (input tvalid, tdata, tkeep, byte_cnt, output tready);
endinterface

// File: rtl/axis_insert_header_pipe.sv
// rtl/axis_insert_header_pipe.sv - prepends a 0..W byte header to each packet with registered output
// Optional packet/flush counters are enabled by defining INS_STATS_EN.
module axis_insert_header_pipe #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                          clk,
    input  logic                          rst,
    axis_insert_header_pipe_if.slave      in_if,
    axis_insert_header_pipe_if.master     out_if,
    axis_insert_header_pipe_hdr_if.slave  insert_if
`ifdef INS_STATS_EN
    ,
    output logic [15:0]                   pkt_cnt,
    output logic [15:0]                   flush_cnt
`endif
);

    localparam int W  = DATA_BYTE_WD;
    localparam int NW = BYTE_CNT_WD + 1;
    localparam logic [NW-1:0] W_N = NW'(W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_STREAM,
        S_FLUSH
    } state_t;

    state_t             state_q, state_d;
    logic [NW-1:0]      n_q, n_d;
    logic [DATA_WD-1:0] r_q, r_d;
    logic [W-1:0]       flush_keep_q, flush_keep_d;

    logic               valid_q, valid_d;
    logic [DATA_WD-1:0] data_q, data_d;
    logic [W-1:0]       keep_q, keep_d;
    logic               last_q, last_d;

    logic               out_free;
    logic               in_ready;
    logic               hdr_ready;
    logic               in_fire;
    logic               hdr_fire;
    logic [NW-1:0]      n_clamp;
    logic [DATA_WD-1:0] packed_beat;
    logic [DATA_WD-1:0] flush_beat;
    int                 n_int;
    int                 m_int;
    int                 sum_int;
    logic               unused_w;

    // Mask selecting the low k bytes of a data word; k == W yields all ones.
    function automatic logic [DATA_WD-1:0] low_bytes_mask(input int k);
        return ~({DATA_WD{1'b1}} << (8 * k));
    endfunction

    function automatic logic [W-1:0] msb_keep(input int k);
        return ~({W{1'b1}} >> k);
    endfunction

    assign out_free  = !valid_q || out_if.tready;
    assign in_ready  = ((state_q == S_HDR) || (state_q == S_STREAM)) && out_free;
    assign hdr_ready = (state_q == S_IDLE);
    assign in_fire   = in_if.tvalid && in_ready;
    assign hdr_fire  = insert_if.tvalid && hdr_ready;
    assign n_clamp   = (insert_if.byte_cnt > W_N) ? W_N : insert_if.byte_cnt;

    assign in_if.tready     = in_ready;
    assign insert_if.tready = hdr_ready;

    assign out_if.tvalid = valid_q;
    assign out_if.tdata  = data_q;
    assign out_if.tkeep  = keep_q;
    assign out_if.tlast  = last_q;

    assign unused_w = ^insert_if.tkeep;

    always_comb begin
        n_int = int'(n_q);
        m_int = 0;
        for (int i = 0; i < W; i++) begin
            if (in_if.tkeep[i]) begin
                m_int = m_int + 1;
            end
        end
        sum_int = n_int + m_int;
    end

    // Residue bytes lead the beat, followed by the first W-n payload bytes.
    always_comb begin
        packed_beat = (r_q << (8 * (W - n_int))) | (in_if.tdata >> (8 * n_int));
        flush_beat  = r_q << (8 * (W - n_int));
    end

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        r_d          = r_q;
        flush_keep_d = flush_keep_q;
        valid_d      = valid_q && !out_if.tready;
        data_d       = data_q;
        keep_d       = keep_q;
        last_d       = last_q;

        case (state_q)
            S_IDLE: begin
                if (hdr_fire) begin
                    n_d     = n_clamp;
                    r_d     = insert_if.tdata & low_bytes_mask(int'(n_clamp));
                    state_d = S_HDR;
                end
            end

            S_HDR, S_STREAM: begin
                if (in_fire) begin
                    valid_d = 1'b1;
                    data_d  = packed_beat;
                    r_d     = in_if.tdata & low_bytes_mask(n_int);
                    if (!in_if.tlast) begin
                        keep_d  = {W{1'b1}};
                        last_d  = 1'b0;
                        state_d = S_STREAM;
                    end else if (sum_int <= W) begin
                        keep_d  = msb_keep(sum_int);
                        last_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        keep_d       = {W{1'b1}};
                        last_d       = 1'b0;
                        flush_keep_d = msb_keep(sum_int - W);
                        state_d      = S_FLUSH;
                    end
                end
            end

            S_FLUSH: begin
                if (out_free) begin
                    valid_d = 1'b1;
                    data_d  = flush_beat;
                    keep_d  = flush_keep_q;
                    last_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            n_q          <= '0;
            r_q          <= '0;
            flush_keep_q <= '0;
            valid_q      <= 1'b0;
            data_q       <= '0;
            keep_q       <= '0;
            last_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            r_q          <= r_d;
            flush_keep_q <= flush_keep_d;
            valid_q      <= valid_d;
            data_q       <= data_d;
            keep_q       <= keep_d;
            last_q       <= last_d;
        end
    end

`ifdef INS_STATS_EN
    logic [15:0] pkt_cnt_q;
    logic [15:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_q   <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (valid_q && out_if.tready && last_q) begin
                pkt_cnt_q <= pkt_cnt_q + 16'd1;
            end
            if ((state_q != S_FLUSH) && (state_d == S_FLUSH)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign pkt_cnt   = pkt_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_axis_insert_header_pipe.sv
// tb/tb_axis_insert_header_pipe.sv - self-checking bench for axis_insert_header_pipe
module tb_axis_insert_header_pipe;

    localparam int DW = 32;
    localparam int W  = 4;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    typedef struct {
        int           cnt;
        logic [31:0]  hdr;
        int           nb;
        logic [127:0] d;
        logic [3:0]   lk;
        int           ne;
        logic [159:0] ed;
        logic [19:0]  ek;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axis_insert_header_pipe_if     #(.DATA_WD(DW)) in_if ();
    axis_insert_header_pipe_if     #(.DATA_WD(DW)) out_if ();
    axis_insert_header_pipe_hdr_if #(.DATA_WD(DW)) ins_if ();

`ifdef INS_STATS_EN
    logic [15:0] pkt_cnt;
    logic [15:0] flush_cnt;
`endif

    axis_insert_header_pipe #(.DATA_WD(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_if     (in_if),
        .out_if    (out_if),
        .insert_if (ins_if)
`ifdef INS_STATS_EN
        ,
        .pkt_cnt   (pkt_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    int    checks    = 0;
    int    failures  = 0;
    int    cyc       = 0;
    int    hdr_cyc   = 0;
    int    first_cyc = 0;
    int    last_cyc  = 0;
    int    pkts_out  = 0;
    int    exp_flush = 0;
    bit    sb_en     = 1'b1;
    bit    bp_en     = 1'b0;
    bit    mon_first = 1'b1;
    bit    stall_prev = 1'b0;
    logic [37:0] held = '0;
    beat_t sb[$];
    vec_t  vt[8];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=handshake", name);
    endtask

    initial begin
        out_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_if.tready = bp_en ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stable_while_stalled",
                    64'({out_if.tvalid, out_if.tlast, out_if.tkeep, out_if.tdata}),
                    64'({1'b1, held[36:0]}));
            end
            if (out_if.tvalid && out_if.tready && sb_en) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=%h required=none", out_if.tdata);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", 64'(out_if.tdata), 64'(e.data));
                    chk("out_keep", 64'(out_if.tkeep), 64'(e.keep));
                    chk("out_last", 64'(out_if.tlast), 64'(e.last));
                end
                if (mon_first) begin
                    first_cyc = cyc;
                    mon_first = 1'b0;
                end
                if (out_if.tlast) begin
                    last_cyc  = cyc;
                    mon_first = 1'b1;
                    pkts_out++;
                end
            end
            stall_prev = out_if.tvalid && !out_if.tready;
            held = {1'b1, out_if.tlast, out_if.tkeep, out_if.tdata};
        end
    end

    task automatic send_hdr(input int cnt, input logic [31:0] hdr);
        bit ok = 1'b0;
        int g  = 0;
        ins_if.tvalid   = 1'b1;
        ins_if.tdata    = hdr;
        ins_if.tkeep    = 4'hF;
        ins_if.byte_cnt = 3'(cnt);
        while (!ok && g < 1000) begin
            @(negedge clk);
            ok = ins_if.tready;
            if (ok) hdr_cyc = cyc;
            @(posedge clk);
            #1;
            g++;
        end
        ins_if.tvalid = 1'b0;
        if (!ok) tmo("hdr_handshake");
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        bit ok = 1'b0;
        int g  = 0;
        in_if.tvalid = 1'b1;
        in_if.tdata  = d;
        in_if.tkeep  = k;
        in_if.tlast  = l;
        while (!ok && g < 1000) begin
            @(negedge clk);
            ok = in_if.tready;
            @(posedge clk);
            #1;
            g++;
        end
        if (!ok) tmo("payload_handshake");
    endtask

    task automatic send_packet(input int cnt, input logic [31:0] hdr, input int nb,
                               input logic [127:0] d, input logic [3:0] lk);
        send_hdr(cnt, hdr);
        for (int i = 0; i < nb; i++) begin
            send_beat(d[127-32*i -: 32], (i == nb - 1) ? lk : 4'hF, (i == nb - 1));
        end
        in_if.tvalid = 1'b0;
    endtask

    task automatic push_vec(input vec_t v);
        beat_t b;
        for (int e = 0; e < v.ne; e++) begin
            b.data = v.ed[159-32*e -: 32];
            b.keep = v.ek[19-4*e -: 4];
            b.last = (e == v.ne - 1);
            sb.push_back(b);
        end
        if (v.ne > v.nb) exp_flush++;
    endtask

    // Byte-level reference: header bytes then payload bytes, re-chunked into W-byte beats.
    task automatic model_push(input int cnt, input logic [31:0] hdr, input int nb,
                              input logic [127:0] d, input logic [3:0] lk);
        logic [7:0]  q[$];
        logic [31:0] beat;
        beat_t       b;
        int n    = (cnt > W) ? W : cnt;
        int m    = $countones(lk);
        int nout;
        for (int j = 0; j < n; j++) q.push_back(hdr[8*(n-1-j) +: 8]);
        for (int i = 0; i < nb; i++) begin
            beat = d[127-32*i -: 32];
            for (int k = 0; k < ((i == nb - 1) ? m : W); k++) q.push_back(beat[31-8*k -: 8]);
        end
        nout = (q.size() + W - 1) / W;
        for (int o = 0; o < nout; o++) begin
            b.data = '0;
            b.keep = '0;
            for (int k = 0; k < W; k++) begin
                if (o * W + k < q.size()) begin
                    b.data[31-8*k -: 8] = q[o*W+k];
                    b.keep[3-k]         = 1'b1;
                end
            end
            b.last = (o == nout - 1);
            sb.push_back(b);
        end
        if (nout > nb) exp_flush++;
    endtask

    task automatic drain();
        int g = 0;
        while (sb.size() != 0 && g < 2000) begin
            @(posedge clk);
            g++;
        end
        @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    endtask

    task automatic random_packets(input int count, input bit fixed_n1);
        int           cnt;
        int           nb;
        int           m;
        logic [31:0]  hdr;
        logic [127:0] d;
        logic [3:0]   lk;
        logic [31:0]  msk;
        for (int p = 0; p < count; p++) begin
            cnt = fixed_n1 ? 1 : $urandom_range(0, 7);
            hdr = $urandom;
            nb  = $urandom_range(1, 4);
            m   = $urandom_range(1, 4);
            lk  = ~(4'hF >> m);
            d   = {$urandom, $urandom, $urandom, $urandom};
            msk = ~(32'hFFFF_FFFF >> (8 * m));
            d[127-32*(nb-1) -: 32] = d[127-32*(nb-1) -: 32] & msk;
            model_push(cnt, hdr, nb, d, lk);
            send_packet(cnt, hdr, nb, d, lk);
        end
    endtask

    initial begin
        vt[0] = '{2, 32'h0000AABB, 2, {32'h11223344, 32'h55667788, 64'h0}, 4'b1111,
                  3, {32'hAABB1122, 32'h33445566, 32'h77880000, 64'h0}, {4'b1111, 4'b1111, 4'b1100, 8'h0}};
        vt[1] = '{3, 32'h00CCDDEE, 1, {32'h99000000, 96'h0}, 4'b1000,
                  1, {32'hCCDDEE99, 128'h0}, {4'b1111, 16'h0}};
        vt[2] = '{0, 32'h12345678, 3, {32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C300, 32'h0}, 4'b1110,
                  3, {32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C300, 64'h0}, {4'b1111, 4'b1111, 4'b1110, 8'h0}};
        vt[3] = '{7, 32'hDEADBEEF, 2, {32'h01020304, 32'h05060700, 64'h0}, 4'b1110,
                  3, {32'hDEADBEEF, 32'h01020304, 32'h05060700, 64'h0}, {4'b1111, 4'b1111, 4'b1110, 8'h0}};
        vt[4] = '{1, 32'h000000AB, 1, {32'h11223300, 96'h0}, 4'b1110,
                  1, {32'hAB112233, 128'h0}, {4'b1111, 16'h0}};
        vt[5] = '{1, 32'h000000CD, 1, {32'h11223344, 96'h0}, 4'b1111,
                  2, {32'hCD112233, 32'h44000000, 96'h0}, {4'b1111, 4'b1000, 12'h0}};
        vt[6] = '{4, 32'h01020304, 1, {32'hAA000000, 96'h0}, 4'b1000,
                  2, {32'h01020304, 32'hAA000000, 96'h0}, {4'b1111, 4'b1000, 12'h0}};
        vt[7] = '{2, 32'h0000EEFF, 2, {32'h10203040, 32'h50600000, 64'h0}, 4'b1100,
                  2, {32'hEEFF1020, 32'h30405060, 96'h0}, {4'b1111, 4'b1111, 12'h0}};

        in_if.tvalid    = 1'b0;
        in_if.tdata     = '0;
        in_if.tkeep     = '0;
        in_if.tlast     = 1'b0;
        ins_if.tvalid   = 1'b0;
        ins_if.tdata    = '0;
        ins_if.tkeep    = '0;
        ins_if.byte_cnt = '0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valid_out", 64'(out_if.tvalid), 64'd0);
        chk("reset_data_out", 64'(out_if.tdata), 64'd0);
        chk("reset_keep_out", 64'(out_if.tkeep), 64'd0);
        chk("reset_last_out", 64'(out_if.tlast), 64'd0);
        chk("reset_ready_in", 64'(in_if.tready), 64'd0);
        chk("reset_ready_insert", 64'(ins_if.tready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            push_vec(vt[i]);
            send_packet(vt[i].cnt, vt[i].hdr, vt[i].nb, vt[i].d, vt[i].lk);
        end
        drain();

        push_vec(vt[2]);
        send_packet(vt[2].cnt, vt[2].hdr, vt[2].nb, vt[2].d, vt[2].lk);
        drain();
        chk("passthru_first_latency", 64'(first_cyc - hdr_cyc), 64'd2);
        chk("passthru_last_latency", 64'(last_cyc - hdr_cyc), 64'd4);

        bp_en = 1'b1;
        random_packets(20, 1'b1);
        random_packets(20, 1'b0);
        drain();
        bp_en = 1'b0;
        @(posedge clk);
        #1;

`ifdef INS_STATS_EN
        chk("stats_pkt_cnt", 64'(pkt_cnt), 64'(pkts_out));
        chk("stats_flush_cnt", 64'(flush_cnt), 64'(exp_flush));
`endif

        sb_en = 1'b0;
        send_hdr(2, 32'h0000A1A2);
        send_beat(32'h11111111, 4'hF, 1'b0);
        in_if.tdata = 32'h22222222;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_if.tvalid = 1'b0;
        @(negedge clk);
        chk("midrst_valid_out", 64'(out_if.tvalid), 64'd0);
        chk("midrst_ready_insert", 64'(ins_if.tready), 64'd1);
        chk("midrst_ready_in", 64'(in_if.tready), 64'd0);
`ifdef INS_STATS_EN
        chk("midrst_pkt_cnt", 64'(pkt_cnt), 64'd0);
`endif
        @(posedge clk);
        #1;
        sb.delete();
        mon_first = 1'b1;
        sb_en = 1'b1;
        push_vec(vt[0]);
        send_packet(vt[0].cnt, vt[0].hdr, vt[0].nb, vt[0].d, vt[0].lk);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
